// File: rtl/data_unpacker_pkg.sv
// Shared definitions for the trace data unpacker: mode encodings, FSM states
// and small sizing helpers.
package data_unpacker_pkg;

    // Mode encodings match the packer firmware's byte values
    localparam logic [7:0] MODE_N = 8'd0;
    localparam logic [7:0] MODE_M = 8'd1;
    localparam logic [7:0] MODE_1 = 8'd2;

    typedef enum logic [0:0] {
        IDLE,
        UNPACK
    } state_t;

    function automatic int sub_w(input int data_width, input int precision);
        return data_width / precision;
    endfunction

    // Lanes carried per beat; zero means the word is dropped
    function automatic int lanes_for_mode(input logic [7:0] mode, input int n, input int m);
        case (mode)
            MODE_N:  return n;
            MODE_M:  return m;
            MODE_1:  return 1;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/data_unpacker_if.sv
// Packed-input / unpacked-output handshake bundle for data_unpacker.
// The master side feeds packed words and consumes unpacked beats.
interface data_unpacker_if #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32
);
    logic                    valid_in;
    logic                    ready_in;
    logic [N*DATA_WIDTH-1:0] vector_in;
    logic                    valid_out;
    logic                    ready_out;
    logic [N*DATA_WIDTH-1:0] vector_out;
    logic [7:0]              lanes_out;

    modport master (
        output valid_in, vector_in, ready_out,
        input  ready_in, valid_out, vector_out, lanes_out
    );

    modport slave (
        input  valid_in, vector_in, ready_out,
        output ready_in, valid_out, vector_out, lanes_out
    );
endinterface

// File: rtl/data_unpacker_slice_select.sv
// Combinational beat builder: picks slice p of lanes g*L .. g*L+L-1 from a
// packed word and zero-extends each sub-value into its output lane.
module unpack_slice_select
    import data_unpacker_pkg::*;
#(
    parameter int N          = 8,
    parameter int M          = 2,
    parameter int DATA_WIDTH = 32,
    parameter int PRECISION  = 2
) (
    input  logic [N*DATA_WIDTH-1:0] word,
    input  logic [7:0]              mode,
    input  logic [7:0]              slice_cnt,
    input  logic [7:0]              group_cnt,
    output logic [N*DATA_WIDTH-1:0] vector,
    output logic [7:0]              lanes
);

    localparam int SUB_W = sub_w(DATA_WIDTH, PRECISION);

    always_comb begin
        int l;
        int idx;
        l      = lanes_for_mode(mode, N, M);
        idx    = 0;
        vector = '0;
        lanes  = 8'(l);
        for (int j = 0; j < N; j++) begin
            idx = int'(group_cnt) * l + j;
            if (j < l && idx < N && int'(slice_cnt) < PRECISION) begin
                vector[j*DATA_WIDTH +: SUB_W] =
                    word[idx*DATA_WIDTH + int'(slice_cnt)*SUB_W +: SUB_W];
            end
        end
    end

endmodule

// File: rtl/data_unpacker.sv
// Trace readback unpacker: splits each packed N-lane word into a stream of
// N-, M- or 1-lane beats in original packing order.
module data_unpacker
    import data_unpacker_pkg::*;
#(
    parameter int         N                  = 8,
    parameter int         M                  = 2,
    parameter int         DATA_WIDTH         = 32,
    parameter int         PRECISION          = 2,
    parameter int         PERSONAL_CONFIG_ID = 0,
    parameter logic [7:0] INITIAL_MODE       = 8'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tracing,
    input  logic [7:0]       configId,
    input  logic [7:0]       configData,
    data_unpacker_if.slave   bus
);

    state_t                  state, state_next;
    logic [7:0]              mode_q;
    logic                    cfg_seen;
    logic [N*DATA_WIDTH-1:0] word_q;
    logic [7:0]              word_mode;
    logic [7:0]              slice_cnt, group_cnt;
    logic [7:0]              slice_nxt, group_nxt;
    logic [7:0]              last_group;
    logic                    last_beat, beat_fire, ready_in_c, accept, new_drop;
    logic                    valid_q;
    logic [N*DATA_WIDTH-1:0] vector_q;
    logic [7:0]              lanes_q;

    logic [N*DATA_WIDTH-1:0] sel_word, sel_vector;
    logic [7:0]              sel_mode, sel_slice, sel_group, sel_lanes;

    unpack_slice_select #(
        .N(N), .M(M), .DATA_WIDTH(DATA_WIDTH), .PRECISION(PRECISION)
    ) u_select (
        .word      (sel_word),
        .mode      (sel_mode),
        .slice_cnt (sel_slice),
        .group_cnt (sel_group),
        .vector    (sel_vector),
        .lanes     (sel_lanes)
    );

    // Group index runs fastest; the last beat also opens ready_in for a bubble-free handoff
    always_comb begin
        case (word_mode)
            MODE_M:  last_group = 8'(N / M - 1);
            MODE_1:  last_group = 8'(N - 1);
            default: last_group = 8'd0;
        endcase
        last_beat  = (slice_cnt == 8'(PRECISION - 1)) && (group_cnt == last_group);
        beat_fire  = valid_q & bus.ready_out;
        ready_in_c = (state == IDLE) || (beat_fire && last_beat);
        accept     = bus.valid_in & ready_in_c;
        new_drop   = (lanes_for_mode(mode_q, N, M) == 0);

        if (group_cnt == last_group) begin
            group_nxt = 8'd0;
            slice_nxt = slice_cnt + 8'd1;
        end else begin
            group_nxt = group_cnt + 8'd1;
            slice_nxt = slice_cnt;
        end

        sel_word  = word_q;
        sel_mode  = word_mode;
        sel_slice = slice_nxt;
        sel_group = group_nxt;
        if (accept) begin
            sel_word  = bus.vector_in;
            sel_mode  = mode_q;
            sel_slice = 8'd0;
            sel_group = 8'd0;
        end

        state_next = state;
        case (state)
            IDLE: begin
                if (accept && !new_drop) state_next = UNPACK;
            end
            UNPACK: begin
                if (beat_fire && last_beat) state_next = (accept && !new_drop) ? UNPACK : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mode_q    <= INITIAL_MODE;
            cfg_seen  <= 1'b0;
            word_q    <= '0;
            word_mode <= 8'd0;
            slice_cnt <= 8'd0;
            group_cnt <= 8'd0;
            valid_q   <= 1'b0;
            vector_q  <= '0;
            lanes_q   <= 8'd0;
        end else begin
            state <= state_next;

            // Only the first byte of a burst addressed to us lands in the mode register
            if (configId != 8'(PERSONAL_CONFIG_ID)) begin
                cfg_seen <= 1'b0;
            end else if (!tracing && !cfg_seen) begin
                mode_q   <= configData;
                cfg_seen <= 1'b1;
            end

            if (accept) begin
                word_q    <= bus.vector_in;
                word_mode <= mode_q;
                slice_cnt <= 8'd0;
                group_cnt <= 8'd0;
                valid_q   <= !new_drop;
                if (!new_drop) begin
                    vector_q <= sel_vector;
                    lanes_q  <= sel_lanes;
                end
            end else if (beat_fire) begin
                if (last_beat) begin
                    valid_q <= 1'b0;
                end else begin
                    slice_cnt <= slice_nxt;
                    group_cnt <= group_nxt;
                    vector_q  <= sel_vector;
                    lanes_q   <= sel_lanes;
                end
            end
        end
    end

    assign bus.ready_in   = ready_in_c;
    assign bus.valid_out  = valid_q;
    assign bus.vector_out = vector_q;
    assign bus.lanes_out  = lanes_q;

endmodule

// File: tb/tb_data_unpacker.sv
// Directed bench for data_unpacker: all modes, backpressure, drop mode and
// mid-word reset, with hand-derived beat contents.
module tb_data_unpacker;

    logic       clk = 1'b0;
    logic       reset;
    logic       tracing;
    logic [7:0] configId;
    logic [7:0] configData;
    int         total = 0;
    int         bad   = 0;

    data_unpacker_if #(.N(8), .DATA_WIDTH(32)) bus ();

    data_unpacker #(
        .N(8), .M(2), .DATA_WIDTH(32), .PRECISION(2),
        .PERSONAL_CONFIG_ID(0), .INITIAL_MODE(8'd0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tracing    (tracing),
        .configId   (configId),
        .configData (configData),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Mode-1 beat b carries lanes {lo, lo+1}: groups step by 2, slice adds 8
    localparam int M1_LO [8] = '{0, 2, 4, 6, 8, 10, 12, 14};

    function automatic logic [255:0] makeWord(input int lo, input int hi);
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = {16'(hi + i), 16'(lo + i)};
        return v;
    endfunction

    function automatic logic [255:0] lanesVec(input int base, input int count);
        logic [255:0] v;
        v = '0;
        for (int j = 0; j < 8; j++) if (j < count) v[j*32 +: 32] = 32'(base + j);
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic vin, input logic [255:0] vec, input logic rout);
        @(negedge clk);
        bus.valid_in  = vin;
        bus.vector_in = vec;
        bus.ready_out = rout;
        #1;
    endtask

    task automatic writeMode(input logic [7:0] m);
        @(negedge clk);
        bus.valid_in = 1'b0;
        tracing      = 1'b0;
        configId     = 8'd0;
        configData   = m;
        @(negedge clk);
        configId     = 8'hFF;
        tracing      = 1'b1;
    endtask

    task automatic checkBeat(input string tag, input logic [255:0] vec, input int lanes);
        checkOutput({tag, "_valid"}, 256'(bus.valid_out), 256'(1));
        checkOutput({tag, "_vec"}, bus.vector_out, vec);
        checkOutput({tag, "_lanes"}, 256'(bus.lanes_out), 256'(lanes));
    endtask

    logic [255:0] w1, w2;

    initial begin
        w1 = makeWord(0, 8);
        w2 = makeWord(16, 24);
        reset = 1'b1; tracing = 1'b1; configId = 8'hFF; configData = 8'd0;
        bus.valid_in = 1'b0; bus.vector_in = '0; bus.ready_out = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("rst_valid", 256'(bus.valid_out), 256'(0));
        checkOutput("rst_vec", bus.vector_out, '0);
        checkOutput("rst_lanes", 256'(bus.lanes_out), 256'(0));
        checkOutput("rst_ready", 256'(bus.ready_in), 256'(1));

        $display("[TB] mode 0 back-to-back");
        applyStimulus(1'b1, w1, 1'b1);
        checkOutput("m0_accept_ready", 256'(bus.ready_in), 256'(1));
        applyStimulus(1'b1, w1, 1'b1);
        checkBeat("m0_b1", lanesVec(0, 8), 8);
        checkOutput("m0_b1_ready", 256'(bus.ready_in), 256'(0));
        applyStimulus(1'b1, w1, 1'b1);
        checkBeat("m0_b2", lanesVec(8, 8), 8);
        checkOutput("m0_b2_ready", 256'(bus.ready_in), 256'(1));
        applyStimulus(1'b0, w1, 1'b1);
        checkBeat("m0_w2_b1", lanesVec(0, 8), 8);
        checkOutput("m0_w2_b1_ready", 256'(bus.ready_in), 256'(0));
        applyStimulus(1'b0, w1, 1'b1);
        checkBeat("m0_w2_b2", lanesVec(8, 8), 8);
        applyStimulus(1'b0, w1, 1'b1);
        checkOutput("m0_idle_valid", 256'(bus.valid_out), 256'(0));

        $display("[TB] mode 1");
        writeMode(8'd1);
        applyStimulus(1'b1, w1, 1'b1);
        checkOutput("m1_accept_ready", 256'(bus.ready_in), 256'(1));
        for (int b = 0; b < 8; b++) begin
            applyStimulus(1'b0, w1, 1'b1);
            checkBeat($sformatf("m1_b%0d", b), lanesVec(M1_LO[b], 2), 2);
        end
        applyStimulus(1'b0, w1, 1'b1);
        checkOutput("m1_done_valid", 256'(bus.valid_out), 256'(0));

        $display("[TB] mode 2");
        writeMode(8'd2);
        applyStimulus(1'b1, w1, 1'b1);
        for (int b = 0; b < 16; b++) begin
            applyStimulus(1'b0, w1, 1'b1);
            checkBeat($sformatf("m2_b%0d", b), lanesVec(b, 1), 1);
        end
        checkOutput("m2_last_ready", 256'(bus.ready_in), 256'(1));
        applyStimulus(1'b0, w1, 1'b1);
        checkOutput("m2_done_valid", 256'(bus.valid_out), 256'(0));

        $display("[TB] mode 0 with backpressure");
        writeMode(8'd0);
        applyStimulus(1'b1, w1, 1'b1);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b1, w2, 1'b0);
            checkBeat($sformatf("stall_c%0d", c), lanesVec(0, 8), 8);
            checkOutput($sformatf("stall_c%0d_ready", c), 256'(bus.ready_in), 256'(0));
        end
        applyStimulus(1'b1, w2, 1'b1);
        checkBeat("stall_release", lanesVec(0, 8), 8);
        applyStimulus(1'b1, w2, 1'b1);
        checkBeat("stall_b2", lanesVec(8, 8), 8);
        checkOutput("stall_b2_ready", 256'(bus.ready_in), 256'(1));
        applyStimulus(1'b0, w2, 1'b1);
        checkBeat("next_b1", lanesVec(16, 8), 8);
        applyStimulus(1'b0, w2, 1'b1);
        checkBeat("next_b2", lanesVec(24, 8), 8);
        applyStimulus(1'b0, w2, 1'b1);

        $display("[TB] drop mode");
        writeMode(8'd7);
        applyStimulus(1'b1, w1, 1'b1);
        checkOutput("drop_w1_ready", 256'(bus.ready_in), 256'(1));
        applyStimulus(1'b1, w2, 1'b1);
        checkOutput("drop_w1_valid", 256'(bus.valid_out), 256'(0));
        checkOutput("drop_w2_ready", 256'(bus.ready_in), 256'(1));
        applyStimulus(1'b0, w2, 1'b1);
        checkOutput("drop_w2_valid", 256'(bus.valid_out), 256'(0));
        writeMode(8'd0);
        applyStimulus(1'b1, w2, 1'b1);
        applyStimulus(1'b0, w2, 1'b1);
        checkBeat("undrop_b1", lanesVec(16, 8), 8);
        applyStimulus(1'b0, w2, 1'b1);
        checkBeat("undrop_b2", lanesVec(24, 8), 8);
        applyStimulus(1'b0, w2, 1'b1);

        $display("[TB] reset mid-word");
        writeMode(8'd2);
        applyStimulus(1'b1, w1, 1'b1);
        applyStimulus(1'b0, w1, 1'b1);
        checkBeat("mid_b0", lanesVec(0, 1), 1);
        applyStimulus(1'b0, w1, 1'b1);
        checkBeat("mid_b1", lanesVec(1, 1), 1);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_valid", 256'(bus.valid_out), 256'(0));
        checkOutput("mid_rst_ready", 256'(bus.ready_in), 256'(1));
        checkOutput("mid_rst_vec", bus.vector_out, '0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b1, w1, 1'b1);
        applyStimulus(1'b0, w1, 1'b1);
        checkBeat("post_rst_b1", lanesVec(0, 8), 8);
        applyStimulus(1'b0, w1, 1'b1);
        checkBeat("post_rst_b2", lanesVec(8, 8), 8);
        applyStimulus(1'b0, w1, 1'b1);
        checkOutput("post_rst_idle", 256'(bus.valid_out), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
